// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmitter FSM state type, the serial data width, the default
// bit period (50 MHz / 115200) and the MMIO address of the UART register.
package uart_pkg;

  localparam int          DATA_W           = 8;
  localparam int          DEF_CLKS_PER_BIT = 434;
  localparam logic [31:0] UART_ADDR        = 32'h1000_0000;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-offer handshake between the store-decode stage and the UART
// transmitter.
//   data  : byte to transmit
//   valid : byte offered this cycle
//   ready : transmitter has room; a byte moves when valid & ready
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for the UART transmitter.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write din when not full
//   pop/dout : dout always shows the head; pop advances it when not empty
//   full/empty : occupancy flags
// Pointers carry one extra bit so full and empty are distinguishable.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, with a transmit FIFO.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset; aborts any frame, drops queue
//   i_data  : byte offered by the decode stage
//   i_valid : offer strobe; byte accepted when i_valid & o_ready
//   o_ready : FIFO not full
//   o_tx    : serial line, idle high, registered
//   o_busy  : frame in flight or bytes queued
// o_tx is registered from the current state, so the line lags the FSM by
// one cycle uniformly: a byte accepted into an idle, empty transmitter
// reaches the start bit two edges later, and every bit keeps its width.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_tx,
  output logic              o_busy
);
  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  uart_tx_state_e    state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [2:0]        bit_idx, bit_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic              tx_nx;
  logic              bit_end;

  logic              push, pop;
  logic [DATA_W-1:0] head;
  logic              full, empty;

  assign push    = i_valid & o_ready & ~i_rst;
  assign o_ready = ~full;
  assign o_busy  = (state != IDLE) | ~empty;
  assign bit_end = (cnt == CNT_MAX);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .din   (i_data),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      o_tx    <= 1'b1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      shreg   <= shreg_nx;
      o_tx    <= tx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_idx;
    shreg_nx = shreg;
    tx_nx    = 1'b1;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shreg_nx = head;
          cnt_nx   = '0;
          bit_nx   = '0;
          state_nx = START;
        end
      end
      START: begin
        tx_nx = 1'b0;
        if (bit_end) begin
          cnt_nx   = '0;
          state_nx = DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        tx_nx = shreg[0];
        if (bit_end) begin
          cnt_nx   = '0;
          shreg_nx = {1'b0, shreg[DATA_W-1:1]};
          bit_nx   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nx = '0;
          // Chain straight into the next start bit when more bytes wait.
          if (!empty) begin
            pop      = 1'b1;
            shreg_nx = head;
            bit_nx   = '0;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=16.
// A line receiver decodes every frame on o_tx into queues (byte, start
// cycle, well-formedness); scenario tasks compare against hand values.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst;
  logic o_tx, o_busy;

  uart_tx_if bus ();

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (bus.data),
    .i_valid (bus.valid),
    .o_ready (bus.ready),
    .o_tx    (o_tx),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q_byte [$];
  int         q_start[$];
  bit         q_ok   [$];

  // Line receiver: sample every cycle of a frame, 2 time units after the edge.
  logic        mon_prev;
  logic [39:0] mon_s;
  logic [7:0]  mon_d;
  bit          mon_ok;
  int          mon_st;
  initial begin
    mon_prev = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (mon_prev === 1'b1 && o_tx === 1'b0) begin
        mon_st   = cyc;
        mon_s[0] = o_tx;
        for (int k = 1; k < FRAME; k++) begin
          @(posedge clk); #2;
          mon_s[k] = o_tx;
        end
        mon_ok = 1'b1;
        for (int g = 0; g < 10; g++)
          for (int j = 1; j < CPB; j++)
            if (mon_s[CPB*g+j] !== mon_s[CPB*g]) mon_ok = 1'b0;
        if (mon_s[0] !== 1'b0 || mon_s[9*CPB] !== 1'b1) mon_ok = 1'b0;
        for (int b = 0; b < 8; b++) mon_d[b] = mon_s[CPB*(b+1)];
        q_byte.push_back(mon_d);
        q_start.push_back(mon_st);
        q_ok.push_back(mon_ok);
        mon_prev = mon_s[FRAME-1];
      end else begin
        mon_prev = o_tx;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    q_byte.delete();
    q_start.delete();
    q_ok.delete();
  endtask

  // Offer one byte; returns the cycle stamp of the accepting edge.
  task automatic push_one(input logic [7:0] b, output int acc);
    bit done;
    done = 1'b0;
    acc  = -1;
    bus.data  = b;
    bus.valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.ready === 1'b1) done = 1'b1;
      tick();
      if (done) acc = cyc;
    end
    bus.valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL push_accept byte=%h got=not_accepted exp=accepted", b);
    end
  endtask

  task automatic wait_frames(input int n, input int budget, output bit to);
    int i;
    i = 0;
    while (q_byte.size() < n && i < budget) begin
      tick();
      i++;
    end
    to = (q_byte.size() < n);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.valid = 1'b0; bus.data = 8'h00;
    tick(); tick();
    checks++; if (o_tx !== 1'b1)      begin failures++; $display("FAIL reset_tx got=%b exp=1", o_tx); end
    checks++; if (o_busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_single();
    int acc; bit to; int g;
    clear_q();
    push_one(8'h55, acc);
    g = 0;
    while (cyc < acc + 40 && g < 100) begin tick(); g++; end
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL single_busy_stop got=%b exp=1", o_busy); end
    tick();
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL single_busy_idle got=%b exp=0", o_busy); end
    wait_frames(1, 100, to);
    checks++;
    if (to) begin
      failures++; $display("FAIL single_frame got=none exp=1_frame");
    end else begin
      checks++; if (q_byte[0] !== 8'h55) begin failures++; $display("FAIL single_byte got=%h exp=55", q_byte[0]); end
      checks++; if (q_ok[0] !== 1'b1)    begin failures++; $display("FAIL single_shape got=%b exp=1", q_ok[0]); end
      checks++;
      if (q_start[0] - acc !== 2) begin
        failures++; $display("FAIL single_latency got=%0d exp=2", q_start[0] - acc);
      end
    end
    checks++; if (o_tx !== 1'b1) begin failures++; $display("FAIL single_idle_tx got=%b exp=1", o_tx); end
    repeat (5) tick();
  endtask

  task automatic test_back_to_back();
    int a1, a2; bit to;
    clear_q();
    push_one(8'hA3, a1);
    push_one(8'h0F, a2);
    checks++; if (a2 - a1 !== 1) begin failures++; $display("FAIL b2b_accept_gap got=%0d exp=1", a2 - a1); end
    wait_frames(2, 200, to);
    checks++;
    if (to) begin
      failures++; $display("FAIL b2b_frames got=%0d exp=2", q_byte.size());
    end else begin
      checks++; if (q_byte[0] !== 8'hA3) begin failures++; $display("FAIL b2b_byte0 got=%h exp=a3", q_byte[0]); end
      checks++; if (q_byte[1] !== 8'h0F) begin failures++; $display("FAIL b2b_byte1 got=%h exp=0f", q_byte[1]); end
      checks++; if ((q_ok[0] & q_ok[1]) !== 1'b1) begin failures++; $display("FAIL b2b_shape got=%b%b exp=11", q_ok[0], q_ok[1]); end
      checks++;
      if (q_start[1] - q_start[0] !== FRAME) begin
        failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", q_start[1] - q_start[0], FRAME);
      end
    end
    repeat (5) tick();
  endtask

  task automatic test_fill();
    int acc[18]; int n; int i; bit take; logic rdy17; bit to;
    clear_q();
    n = 0; i = 0; rdy17 = 1'bx;
    bus.data = 8'h10; bus.valid = 1'b1;
    while (n < 18 && i < 300) begin
      take = (bus.ready === 1'b1);
      tick(); i++;
      if (take) begin
        acc[n] = cyc;
        n++;
        if (n == 17) rdy17 = bus.ready;
        bus.data = 8'(8'h10 + n);
      end
    end
    bus.valid = 1'b0;
    checks++; if (n !== 18) begin failures++; $display("FAIL fill_count got=%0d exp=18", n); end
    checks++; if (rdy17 !== 1'b0) begin failures++; $display("FAIL fill_ready_drop got=%b exp=0", rdy17); end
    if (n == 18) begin
      checks++;
      if (acc[17] - acc[16] > 41) begin
        failures++; $display("FAIL fill_18th_wait got=%0d exp=<=41", acc[17] - acc[16]);
      end
      checks++;
      if (acc[17] - acc[0] !== 42) begin
        failures++; $display("FAIL fill_18th_time got=%0d exp=42", acc[17] - acc[0]);
      end
    end
    wait_frames(18, 18 * FRAME + 100, to);
    checks++;
    if (to) begin
      failures++; $display("FAIL fill_frames got=%0d exp=18", q_byte.size());
    end else begin
      for (int k = 0; k < 18; k++) begin
        checks++;
        if (q_byte[k] !== 8'(8'h10 + k) || q_ok[k] !== 1'b1 ||
            (k > 0 && q_start[k] - q_start[k-1] !== FRAME)) begin
          failures++;
          $display("FAIL fill_frame%0d got=%h ok=%b exp=%h ok=1 spaced=%0d", k, q_byte[k], q_ok[k],
                   8'(8'h10 + k), FRAME);
        end
      end
    end
    repeat (5) tick();
  endtask

  task automatic test_reset_mid_frame();
    int a0, a; int g; int zeros;
    clear_q();
    push_one(8'hFF, a0);
    for (int k = 0; k < 5; k++) push_one(8'(8'h21 + k), a);
    g = 0;
    while (cyc < a0 + 18 && g < 100) begin tick(); g++; end
    rst = 1'b1; bus.valid = 1'b1; bus.data = 8'h77;
    tick();
    checks++; if (o_tx !== 1'b1)      begin failures++; $display("FAIL rstmid_tx got=%b exp=1", o_tx); end
    checks++; if (o_busy !== 1'b0)    begin failures++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", bus.ready); end
    tick();
    rst = 1'b0; bus.valid = 1'b0;
    tick();
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rstmid_push_ignored got=%b exp=0", o_busy); end
    zeros = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (o_tx !== 1'b1) zeros++;
    end
    checks++; if (zeros !== 0) begin failures++; $display("FAIL rstmid_no_frames got=%0d exp=0", zeros); end
    clear_q();
  endtask

  task automatic test_hold_not_ready();
    int n; int i; int low; bit take; bit to;
    clear_q();
    n = 0; i = 0; low = 0;
    bus.data = 8'h40; bus.valid = 1'b1;
    while (n < 18 && i < 300) begin
      take = (bus.ready === 1'b1);
      if (!take && n == 17) low++;
      tick(); i++;
      if (take) begin
        n++;
        bus.data = (n >= 17) ? 8'hC3 : 8'(8'h40 + n);
      end
    end
    bus.valid = 1'b0;
    checks++; if (n !== 18) begin failures++; $display("FAIL hold_count got=%0d exp=18", n); end
    checks++; if (low < 20) begin failures++; $display("FAIL hold_low_cycles got=%0d exp=>=20", low); end
    wait_frames(18, 18 * FRAME + 100, to);
    repeat (60) tick();
    checks++;
    if (q_byte.size() !== 18) begin
      failures++; $display("FAIL hold_frames got=%0d exp=18", q_byte.size());
    end else begin
      checks++; if (q_byte[16] !== 8'h50) begin failures++; $display("FAIL hold_byte16 got=%h exp=50", q_byte[16]); end
      checks++; if (q_byte[17] !== 8'hC3) begin failures++; $display("FAIL hold_byte17 got=%h exp=c3", q_byte[17]); end
    end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL hold_busy_end got=%b exp=0", o_busy); end
  endtask

  initial begin
    rst = 1'b1;
    bus.valid = 1'b0;
    bus.data  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_reset_mid_frame();
    test_hold_not_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
